// File: rtl/bcd_time_keeper_if.sv
// rtl/bcd_time_keeper_if.sv - control inputs and BCD display outputs of the time keeper
interface bcd_time_keeper_if;
  logic       run;
  logic       mode_12h;
  logic       adj_min;
  logic       adj_hrs;
  logic       alarm_set;
  logic [4:0] alarm_hrs;
  logic [5:0] alarm_min;
  logic       alarm_ack;
  logic [1:0] hrs_d;
  logic [3:0] hrs_u;
  logic [2:0] min_d;
  logic [3:0] min_u;
  logic [2:0] sec_d;
  logic [3:0] sec_u;
  logic       pm;
  logic       sec_tick;
  logic       blink;
  logic       alarm;

  modport master (
    output run, mode_12h, adj_min, adj_hrs, alarm_set, alarm_hrs, alarm_min, alarm_ack,
    input  hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, pm, sec_tick, blink, alarm
  );

  modport slave (
    input  run, mode_12h, adj_min, adj_hrs, alarm_set, alarm_hrs, alarm_min, alarm_ack,
    output hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, pm, sec_tick, blink, alarm
  );
endinterface

// File: rtl/bcd_time_keeper.sv
// rtl/bcd_time_keeper.sv - BCD time-of-day counter with 12/24 h display and per-second tick
// Alarm registers, compare and alarm output exist only when BCD_TIME_KEEPER_ALARM_EN is defined.
module bcd_time_keeper #(
  parameter int TICKS_PER_SEC = 31_500_000,
  parameter int RESET_HRS     = 0,
  parameter int RESET_MIN     = 0,
  parameter int RESET_SEC     = 0
) (
  input logic              px_clk,
  input logic              reset,
  bcd_time_keeper_if.slave tk
);
  localparam int            PW         = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICKS_PER_SEC / 2);
  localparam logic [5:0]    RST_H      = {2'(RESET_HRS / 10), 4'(RESET_HRS % 10)};
  localparam logic [6:0]    RST_M      = {3'(RESET_MIN / 10), 4'(RESET_MIN % 10)};
  localparam logic [6:0]    RST_S      = {3'(RESET_SEC / 10), 4'(RESET_SEC % 10)};

  // Digit pairs are held as {tens, units}; increments never pass through an illegal code.
  function automatic logic [6:0] sexa_inc(input logic [6:0] v);
    if (v[3:0] != 4'd9) return {v[6:4], v[3:0] + 4'd1};
    if (v[6:4] != 3'd5) return {v[6:4] + 3'd1, 4'd0};
    return 7'd0;
  endfunction

  function automatic logic [5:0] hour_inc(input logic [5:0] v);
    if (v == 6'h23) return 6'd0;
    if (v[3:0] == 4'd9) return {v[5:4] + 2'd1, 4'd0};
    return {v[5:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [5:0] hour_disp(input logic [4:0] hb, input logic mode_12h);
    logic [4:0] d;
    d = hb;
    if (mode_12h && hb == 5'd0) d = 5'd12;
    else if (mode_12h && hb > 5'd12) d = hb - 5'd12;
    if (d >= 5'd20) return {2'd2, 4'(d - 5'd20)};
    if (d >= 5'd10) return {2'd1, 4'(d - 5'd10)};
    return {2'd0, d[3:0]};
  endfunction

  logic [PW-1:0] presc, presc_n;
  logic [5:0]    hrs, hrs_n;
  logic [6:0]    mins, mins_n, secs, secs_n;
  logic          tick, adj, tick_q;
  logic [4:0]    hrs_bin;
  logic [5:0]    hrs_out;
  logic [6:0]    min_out, sec_out;
  logic          pm_q, blink_q, sec_tick_q;

  assign tick    = tk.run && (presc == PRESC_LAST);
  assign adj     = tk.adj_min | tk.adj_hrs;
  assign hrs_bin = 5'(hrs[5:4]) * 5'd10 + 5'(hrs[3:0]);

  always_comb begin
    presc_n = presc;
    hrs_n   = hrs;
    mins_n  = mins;
    secs_n  = secs;
    if (adj) begin
      // An adjust swallows any tick landing in the same cycle.
      presc_n = '0;
      if (tk.adj_min) begin
        mins_n = sexa_inc(mins);
        secs_n = '0;
      end
      if (tk.adj_hrs) hrs_n = hour_inc(hrs);
    end else if (tick) begin
      presc_n = '0;
      secs_n  = sexa_inc(secs);
      if (secs == 7'h59) begin
        mins_n = sexa_inc(mins);
        if (mins == 7'h59) hrs_n = hour_inc(hrs);
      end
    end else if (tk.run) begin
      presc_n = presc + PW'(1);
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      presc  <= '0;
      hrs    <= RST_H;
      mins   <= RST_M;
      secs   <= RST_S;
      tick_q <= 1'b0;
    end else begin
      presc  <= presc_n;
      hrs    <= hrs_n;
      mins   <= mins_n;
      secs   <= secs_n;
      tick_q <= tick & ~adj;
    end
  end

  // Display stage trails the time state by one cycle, so sec_tick is delayed to match.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      hrs_out    <= hour_disp(5'(RESET_HRS), tk.mode_12h);
      min_out    <= RST_M;
      sec_out    <= RST_S;
      pm_q       <= (RESET_HRS >= 12);
      blink_q    <= 1'b1;
      sec_tick_q <= 1'b0;
    end else begin
      hrs_out    <= hour_disp(hrs_bin, tk.mode_12h);
      min_out    <= mins;
      sec_out    <= secs;
      pm_q       <= (hrs_bin >= 5'd12);
      sec_tick_q <= tick_q;
      if (tk.run) blink_q <= (presc < PRESC_HALF);
    end
  end

  assign tk.hrs_d    = hrs_out[5:4];
  assign tk.hrs_u    = hrs_out[3:0];
  assign tk.min_d    = min_out[6:4];
  assign tk.min_u    = min_out[3:0];
  assign tk.sec_d    = sec_out[6:4];
  assign tk.sec_u    = sec_out[3:0];
  assign tk.pm       = pm_q;
  assign tk.sec_tick = sec_tick_q;
  assign tk.blink    = blink_q;

`ifdef BCD_TIME_KEEPER_ALARM_EN
  logic [4:0] al_hrs;
  logic [5:0] al_min;
  logic [5:0] min_bin;
  logic       alarm_q;

  assign min_bin = 6'(mins[6:4]) * 6'd10 + 6'(mins[3:0]);

  // tick_q marks the cycle holding a tick-produced time, so adjust-made matches never fire.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      al_hrs  <= '0;
      al_min  <= '0;
      alarm_q <= 1'b0;
    end else begin
      if (tk.alarm_set) begin
        al_hrs <= tk.alarm_hrs;
        al_min <= tk.alarm_min;
      end
      if (tk.alarm_ack) alarm_q <= 1'b0;
      else if (tick_q && hrs_bin == al_hrs && min_bin == al_min && secs == 7'd0) alarm_q <= 1'b1;
    end
  end

  assign tk.alarm = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{tk.alarm_set, tk.alarm_hrs, tk.alarm_min, tk.alarm_ack};
  assign tk.alarm     = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_time_keeper.sv
// tb/tb_bcd_time_keeper.sv - self-checking bench for bcd_time_keeper against a seconds-of-day model
module tb_bcd_time_keeper;
  localparam int TPS   = 4;
  localparam int RST_T = 23 * 3600 + 59 * 60 + 58;
`ifdef BCD_TIME_KEEPER_ALARM_EN
  localparam bit AL_EN = 1'b1;
`else
  localparam bit AL_EN = 1'b0;
`endif

  logic px_clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  bcd_time_keeper_if bus ();

  bcd_time_keeper #(
    .TICKS_PER_SEC(TPS),
    .RESET_HRS(23),
    .RESET_MIN(59),
    .RESET_SEC(58)
  ) dut (
    .px_clk(px_clk),
    .reset(reset),
    .tk(bus)
  );

  always #5 px_clk = ~px_clk;

  logic [23:0] act;
  assign act = {bus.hrs_d, bus.hrs_u, bus.min_d, bus.min_u, bus.sec_d, bus.sec_u,
                bus.pm, bus.sec_tick, bus.blink, bus.alarm};

  // Model: time as seconds of day, prescaler as an integer, outputs one cycle behind.
  int m_t, m_p, m_disp, m_ah, m_am;
  bit m_mode, m_blink, m_stick, m_tick1, m_alarm;

  task automatic model_edge();
    int h, mi, s;
    bit tick, adj;
    if (reset) begin
      m_t = RST_T; m_p = 0; m_disp = RST_T; m_mode = bus.mode_12h; m_blink = 1'b1;
      m_stick = 1'b0; m_tick1 = 1'b0; m_alarm = 1'b0; m_ah = 0; m_am = 0;
      return;
    end
    m_disp  = m_t;
    m_mode  = bus.mode_12h;
    if (bus.run) m_blink = (m_p < TPS / 2);
    m_stick = m_tick1;
    if (AL_EN) begin
      if (bus.alarm_ack) m_alarm = 1'b0;
      else if (m_tick1 && m_t == m_ah * 3600 + m_am * 60) m_alarm = 1'b1;
      if (bus.alarm_set) begin m_ah = bus.alarm_hrs; m_am = bus.alarm_min; end
    end
    tick = bus.run && (m_p == TPS - 1);
    adj  = bus.adj_min || bus.adj_hrs;
    h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
    if (adj) begin
      m_p = 0;
      if (bus.adj_min) begin mi = (mi + 1) % 60; s = 0; end
      if (bus.adj_hrs) h = (h + 1) % 24;
      m_t = h * 3600 + mi * 60 + s;
    end else if (tick) begin
      m_p = 0;
      m_t = (m_t + 1) % 86400;
    end else if (bus.run) begin
      m_p++;
    end
    m_tick1 = tick && !adj;
  endtask

  function automatic logic [23:0] exp_vec();
    int h, mi, s, hd;
    h = m_disp / 3600; mi = (m_disp / 60) % 60; s = m_disp % 60;
    hd = h;
    if (m_mode) begin
      if (h == 0) hd = 12;
      else if (h > 12) hd = h - 12;
    end
    return {2'(hd / 10), 4'(hd % 10), 3'(mi / 10), 4'(mi % 10), 3'(s / 10), 4'(s % 10),
            (h >= 12), m_stick, m_blink, m_alarm};
  endfunction

  task automatic step();
    @(posedge px_clk);
    model_edge();
    @(negedge px_clk);
  endtask

  task automatic pulse_min();
    bus.adj_min = 1'b1; step(); bus.adj_min = 1'b0;
  endtask

  task automatic pulse_hrs();
    bus.adj_hrs = 1'b1; step(); bus.adj_hrs = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.run = 1'b1;
    step(); step();
    checks++;
    if (act !== exp_vec()) begin
      errors++; $display("FAIL reset_model: got %h expected %h", act, exp_vec());
    end
    checks++;
    if (act !== {2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_value: got %h expected 23:59:58 pm=1 tick=0 blink=1 alarm=0", act);
    end
  endtask

  task automatic test_rollover();
    bit legal;
    reset = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL rollover_cyc%0d: got %h expected %h", c, act, exp_vec());
      end
      legal = bus.hrs_u <= 9 && bus.min_d <= 5 && bus.min_u <= 9 && bus.sec_d <= 5 &&
              bus.sec_u <= 9 && (bus.hrs_d < 2 || (bus.hrs_d == 2 && bus.hrs_u <= 3));
      checks++;
      if (!legal) begin
        errors++; $display("FAIL rollover_legal_cyc%0d: got digits %h required legal BCD", c, act[23:4]);
      end
      if (c == 5) begin
        checks++;
        if ({act[23:4], act[2]} !== {2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9, 1'b1}) begin
          errors++; $display("FAIL rollover_235959: got %h expected 23:59:59 with sec_tick", act);
        end
      end
      if (c == 9) begin
        checks++;
        if ({act[23:4], act[2]} !== {20'd0, 1'b1}) begin
          errors++; $display("FAIL rollover_000000: got %h expected 00:00:00 with sec_tick", act);
        end
      end
    end
  endtask

  task automatic test_12h();
    bit found = 1'b0;
    bus.mode_12h = 1'b1;
    step();
    checks++;
    if ({act[23:18], act[3]} !== {2'd1, 4'd2, 1'b0}) begin
      errors++; $display("FAIL 12h_midnight: got hrs %h pm %b expected 12 pm 0", act[23:18], act[3]);
    end
    bus.run = 1'b0;
    for (int i = 0; i < 12; i++) pulse_hrs();
    for (int i = 0; i < 59; i++) pulse_min();
    bus.run = 1'b1;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL 12h_cyc%0d: got %h expected %h", k, act, exp_vec());
      end
      if (m_stick && m_disp == 13 * 3600) begin
        found = 1'b1;
        checks++;
        if ({act[23:4], act[3]} !== {2'd0, 4'd1, 3'd0, 4'd0, 3'd0, 4'd0, 1'b1}) begin
          errors++; $display("FAIL 12h_one_pm: got %h expected 01:00:00 pm 1", act);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL 12h_wait: got no 13:00:00 tick expected one within 300 cycles");
    end
    bus.mode_12h = 1'b0;
  endtask

  task automatic count_to_tick(input string name, input int want);
    int got = 0;
    for (int k = 1; k <= 10 && got == 0; k++) begin
      step();
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL %s_cyc%0d: got %h expected %h", name, k, act, exp_vec());
      end
      if (act[2]) got = k;
    end
    checks++;
    if (got != want) begin
      errors++; $display("FAIL %s_latency: got sec_tick at cycle %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_adjust();
    bit found = 1'b0;
    int s0;
    bus.run = 1'b0;
    for (int i = 0; i < 24 && m_t / 3600 != 10; i++) pulse_hrs();
    for (int i = 0; i < 60 && (m_t / 60) % 60 != 59; i++) pulse_min();
    bus.run = 1'b1;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL adjust_run_cyc%0d: got %h expected %h", k, act, exp_vec());
      end
      found = (m_t == 10 * 3600 + 59 * 60 + 37);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL adjust_wait: got no 10:59:37 expected one within 200 cycles");
    end
    pulse_min();
    step();
    checks++;
    if ({act[23:4], act[2]} !== {2'd1, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL adjust_min_wrap: got %h expected 10:00:00 no sec_tick", act);
    end
    count_to_tick("adjust_min", 4);
    bus.run = 1'b0;
    for (int i = 0; i < 24 && m_t / 3600 != 23; i++) pulse_hrs();
    s0 = m_t % 60;
    pulse_hrs();
    step();
    checks++;
    if ({act[23:18], act[10:4]} !== {6'd0, 3'(s0 / 10), 4'(s0 % 10)}) begin
      errors++; $display("FAIL adjust_hrs_wrap: got hrs %h sec %h expected 00 and sec %0d", act[23:18], act[10:4], s0);
    end
  endtask

  task automatic test_collision();
    int mi0;
    bus.run = 1'b1;
    for (int k = 0; k < 8 && m_p != TPS - 1; k++) step();
    mi0 = ((m_t / 60) % 60 + 1) % 60;
    pulse_min();
    step();
    checks++;
    if ({act[17:4], act[2]} !== {3'(mi0 / 10), 4'(mi0 % 10), 7'd0, 1'b0}) begin
      errors++; $display("FAIL collision_value: got min/sec %h tick %b expected min %0d sec 00 no tick", act[17:4], act[2], mi0);
    end
    count_to_tick("collision", 4);
  endtask

  task automatic test_pause_blink();
    logic [23:0] held;
    bus.run = 1'b1;
    step(); step();
    bus.run = 1'b0;
    step(); step();
    held = exp_vec();
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (act !== held) begin
        errors++; $display("FAIL pause_cyc%0d: got %h expected frozen %h", k, act, held);
      end
    end
    bus.run = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (act !== {2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL midreset_value: got %h expected 23:59:58 pm=1 tick=0 blink=1 alarm=0", act);
    end
    count_to_tick("midreset", 5);
  endtask

  task automatic test_alarm();
    bit found = 1'b0;
    bus.run = 1'b0;
    bus.alarm_hrs = 5'd7; bus.alarm_min = 6'd30; bus.alarm_set = 1'b1;
    step();
    bus.alarm_set = 1'b0;
    for (int i = 0; i < 24 && m_t / 3600 != 7; i++) pulse_hrs();
    for (int i = 0; i < 60 && (m_t / 60) % 60 != 29; i++) pulse_min();
    bus.run = 1'b1;
    for (int k = 0; k < 400 && !found; k++) begin
      step();
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL alarm_run_cyc%0d: got %h expected %h", k, act, exp_vec());
      end
      if (m_stick && m_disp == 7 * 3600 + 30 * 60) begin
        found = 1'b1;
        checks++;
        if ({act[23:4], act[2], act[0]} !== {2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0, 1'b1, AL_EN}) begin
          errors++; $display("FAIL alarm_rise: got %h expected 07:30:00 tick=1 alarm=%0b", act, AL_EN);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL alarm_wait: got no 07:30:00 tick expected one within 400 cycles");
    end
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (act[0] !== AL_EN) begin
      errors++; $display("FAIL alarm_hold: got %b expected %b", act[0], AL_EN);
    end
    bus.alarm_ack = 1'b1; step(); bus.alarm_ack = 1'b0;
    checks++;
    if (act[0] !== 1'b0) begin
      errors++; $display("FAIL alarm_ack: got %b expected 0", act[0]);
    end
    bus.run = 1'b0;
    for (int i = 0; i < 60; i++) pulse_min();
    step();
    checks++;
    if ({act[23:4], act[0]} !== {2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL alarm_adjust: got %h expected 07:30:00 alarm=0", act);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      reset         = ($urandom_range(0, 199) == 0);
      bus.run       = ($urandom_range(0, 9) != 0);
      bus.mode_12h  = ($urandom_range(0, 15) == 0) ? ~bus.mode_12h : bus.mode_12h;
      bus.adj_min   = ($urandom_range(0, 15) == 0);
      bus.adj_hrs   = ($urandom_range(0, 19) == 0);
      bus.alarm_set = ($urandom_range(0, 29) == 0);
      bus.alarm_hrs = 5'(m_t / 3600);
      bus.alarm_min = 6'(((m_t / 60) % 60 + $urandom_range(0, 1)) % 60);
      bus.alarm_ack = ($urandom_range(0, 39) == 0);
      step();
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL random_cyc%0d: got %h expected %h", k, act, exp_vec());
      end
    end
    reset = 1'b0; bus.adj_min = 1'b0; bus.adj_hrs = 1'b0;
    bus.alarm_set = 1'b0; bus.alarm_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.run = 1'b0; bus.mode_12h = 1'b0; bus.adj_min = 1'b0; bus.adj_hrs = 1'b0;
    bus.alarm_set = 1'b0; bus.alarm_hrs = 5'd0; bus.alarm_min = 6'd0; bus.alarm_ack = 1'b0;
    @(negedge px_clk);
    test_reset();
    test_rollover();
    test_12h();
    test_adjust();
    test_collision();
    test_pause_blink();
    test_alarm();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_time_keeper.md
# bcd_time_keeper

Parametrised time-of-day counter for the VGA clock. It divides px_clk down to a one-second tick and keeps hours, minutes and seconds as always-legal BCD digits. It supports a 12/24-hour display mode, run/pause, and minute/hour adjust pulses, with an optional alarm. It feeds the digit/font renderer directly, and supplies the colon blink and a per-second tick.

## Interface
- TICKS_PER_SEC, 31_500_000: px_clk cycles per second; must be ≥ 2.
- RESET_HRS, 0: hour loaded on reset (binary, 0..23).
- RESET_MIN, 0: minute loaded on reset (binary, 0..59).
- RESET_SEC, 0: second loaded on reset (binary, 0..59).
- px_clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  1 = prescaler advances; 0 = time frozen.
- mode_12h  in  1  0 = 24 h display, 1 = 12 h display.
- adj_min  in  1  single-cycle pulse, pre-synchronised; advance minutes.
- adj_hrs  in  1  single-cycle pulse, pre-synchronised; advance hours.
- alarm_set  in  1  load alarm time from alarm_hrs/alarm_min.
- alarm_hrs  in  5  alarm hour, binary 0..23.
- alarm_min  in  6  alarm minute, binary 0..59.
- alarm_ack  in  1  clears alarm.
- hrs_d  out  2 / hrs_u  out  4: displayed hour tens/units, BCD.
- min_d  out  3 / min_u  out  4: minute tens/units, BCD.
- sec_d  out  3 / sec_u  out  4: second tens/units, BCD.
- pm  out  1  internal hour ≥ 12.
- sec_tick  out  1  one-cycle pulse coincident with each seconds-driven display update.
- blink  out  1  high during first half of each second.
- alarm  out  1  alarm active.

## Operation
- Prescaler width is $clog2(TICKS_PER_SEC).
- Prescaler counts 0..TICKS_PER_SEC-1 while run=1. The internal tick fires on the cycle where it equals TICKS_PER_SEC-1; the prescaler then wraps to 0.
- Internal state is 24 h BCD: sec 00..59, min 00..59, hour 00..23.
- Digits are never outside range, including transiently. The full carry chain resolves in the tick cycle: 23:59:59 → 00:00:00 in one step.
- adj_min: minutes +1, 59 → 00, no carry into hours. Also clears seconds to 00 and the prescaler to 0.
- adj_hrs: hours +1, 23 → 00. Prescaler cleared; seconds unchanged.
- Either adjust in a cycle discards that cycle's tick. Both adjusts together apply both.
- Display mapping, mode_12h=0: display = internal hour.
- Display mapping, mode_12h=1: 0 → 12, 13..23 → 1..11, 1..12 unchanged.
- pm follows the internal hour in both modes.
- blink = 1 while prescaler < TICKS_PER_SEC/2 (integer division). blink holds its value while run=0.
- Alarm: alarm_set loads the alarm registers. alarm rises when a tick produces hour==alarm_hrs, min==alarm_min, sec==00. Adjust-driven matches do not trigger it.
- alarm stays high until alarm_ack; alarm_ack has priority over a same-cycle match.
- Reset, including mid-count: time = RESET_HRS:RESET_MIN:RESET_SEC, prescaler 0, sec_tick 0, alarm 0, alarm registers 00:00.
- Output values during reset are the RESET_* values in current mode, blink 1.

## Timing
- State registers update on the px_clk edge where a tick or adjust is sampled.
- Display outputs, pm and blink are registered from state, one cycle later.
- sec_tick asserts in the same cycle the new seconds value appears on the outputs.
- mode_12h change is visible on the outputs one cycle later; time state is unaffected.
- After reset deasserts, the first tick occurs TICKS_PER_SEC cycles later (run=1 throughout). sec_tick follows one cycle after that.
- run=0 freezes the prescaler; run=1 resumes from the held count.
- alarm asserts in the same cycle as the matching sec_tick.

## Configuration
- BCD_TIME_KEEPER_ALARM_EN defined: alarm registers, compare and alarm output are implemented as above.
- Undefined: alarm is tied to 0, alarm_set/alarm_hrs/alarm_min/alarm_ack are ignored, and no alarm registers exist.
- Ports are identical in both builds.

## Test plan
All tests use TICKS_PER_SEC=4.
- Rollover: RESET 23:59:58, run=1 → 23:59:59 after 4 cycles + 1, then 00:00:00 on the next sec_tick. No intermediate illegal digit, checked every cycle.
- 12 h mode: RESET 00:00:00, mode_12h=1 → hrs 12, pm 0. Run to 12:59:59 then one tick → display 01:00:00, pm 1.
- Adjust: at 10:59:37, pulse adj_min → 10:00:00, prescaler 0, no sec_tick that cycle. Pulse adj_hrs at 23:xx → 00:xx, seconds kept.
- Tick/adjust collision: assert adj_min on the prescaler==3 cycle → minutes +1, seconds 00, tick discarded. Next sec_tick exactly 4 cycles later.
- Pause/blink/reset: run=0 for 20 cycles → outputs and blink constant. Reset asserted mid-second → RESET values and prescaler 0 the next cycle.
- Alarm (ALARM_EN): set 07:30, start 07:29:58 → alarm rises with the sec_tick showing 07:30:00. Holds until alarm_ack; no trigger via adj_min onto 07:30. Without the macro, alarm stays 0.
